// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Instruction fetch front end. Owns the fetch PC, issues
//                word-aligned requests over a req/gnt/rvalid interface,
//                buffers returned words tagged with their PC and hands them
//                to decode through a valid/ready handshake. Redirects flush
//                the buffered path and drop in-flight responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  // Pointer width for the circular queues, counter width able to hold
  // FIFO_DEPTH, and a wider width for the credit sum of three counters.
  localparam int            AW       = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int            CW       = $clog2(FIFO_DEPTH + 1);
  localparam int            SW       = CW + 2;
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
  localparam logic [SW-1:0] DEPTH_S  = SW'(FIFO_DEPTH);

  // Architectural fetch PC
  logic [31:0]   pc;

  // Requests granted on the current path and not yet answered
  logic [CW-1:0] outstanding;
  // Responses still owed by memory for a path abandoned by a redirect
  logic [CW-1:0] discard;
  // Instructions held in the instruction queue
  logic [CW-1:0] count;

  // Pending-PC queue: PC of every granted current-path request, in order
  logic [31:0]   pend_mem [FIFO_DEPTH];
  logic [AW-1:0] pend_wr;
  logic [AW-1:0] pend_rd;

  // Instruction queue: returned word plus the PC it was fetched from
  logic [31:0]   iq_instr [FIFO_DEPTH];
  logic [31:0]   iq_pc    [FIFO_DEPTH];
  logic [AW-1:0] iq_wr;
  logic [AW-1:0] iq_rd;

  logic [SW-1:0] in_flight;
  logic          issue;
  logic          resp_drop;
  logic          resp_keep;
  logic          resp_any;
  logic          iq_push;
  logic          iq_pop;
  logic [31:0]   redirect_pc;
  logic          unused_addr_bits;

  // Advance a circular-queue pointer, wrapping after the last entry
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // The low redirect-target bits are defined to be ignored
  assign unused_addr_bits = ^redirect_addr[1:0];
  assign redirect_pc      = {redirect_addr[31:2], 2'b00};

  // Credit is taken from registered state only: a pop in the same cycle
  // does not free a slot until the next cycle, keeping gnt/rvalid off the
  // request path.
  assign in_flight = SW'(outstanding) + SW'(discard) + SW'(count);
  assign imem_req  = !rst && !redirect && (in_flight < DEPTH_S);
  assign imem_addr = pc;
  assign issue     = imem_req && imem_gnt;

  // A response first pays off stale-path debt; only then does it belong to
  // the current path. A response with nothing owed is ignored.
  assign resp_drop = imem_rvalid && (discard != '0);
  assign resp_keep = imem_rvalid && (discard == '0) && (outstanding != '0);
  assign resp_any  = resp_drop || resp_keep;

  // In a redirect cycle the kept response is discarded and the queue is
  // flushed, so neither a push nor a pop takes place.
  assign iq_push = resp_keep && !redirect;
  assign iq_pop  = instr_valid && instr_ready && !redirect;

  // Head of the queue; data is forced to zero while the queue is empty
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? iq_instr[iq_rd] : '0;
  assign instr_pc    = instr_valid ? iq_pc[iq_rd]    : '0;

  // Fetch PC: reset vector, redirect target, or +4 per issued request
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VECTOR;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (issue) begin
      pc <= pc + 32'd4;
    end
  end

  // Outstanding and discard bookkeeping; a redirect moves all current-path
  // requests into the discard debt, less any response consumed this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      outstanding <= '0;
      discard     <= discard + outstanding - CW'(resp_any);
    end else begin
      case ({issue, resp_keep})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (resp_drop) begin
        discard <= discard - 1'b1;
      end
    end
  end

  // Instruction-queue occupancy
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      count <= '0;
    end else begin
      case ({iq_push, iq_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pending-PC queue pointers; flushed together with the instruction queue
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      pend_wr <= '0;
      pend_rd <= '0;
    end else begin
      if (issue) begin
        pend_wr <= next_ptr(pend_wr);
      end
      if (resp_keep) begin
        pend_rd <= next_ptr(pend_rd);
      end
    end
  end

  // Pending-PC storage: remember the address of each granted request
  always_ff @(posedge clk) begin
    if (issue) begin
      pend_mem[pend_wr] <= pc;
    end
  end

  // Instruction-queue pointers
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      iq_wr <= '0;
      iq_rd <= '0;
    end else begin
      if (iq_push) begin
        iq_wr <= next_ptr(iq_wr);
      end
      if (iq_pop) begin
        iq_rd <= next_ptr(iq_rd);
      end
    end
  end

  // Instruction-queue storage: returned word paired with its request PC
  always_ff @(posedge clk) begin
    if (iq_push) begin
      iq_instr[iq_wr] <= imem_rdata;
      iq_pc[iq_wr]    <= pend_mem[pend_rd];
    end
  end

endmodule
`default_nettype wire
